param_sync_fifo: RTL

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 80 ++++++++
 1 files changed

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parameterised single-clock FIFO with registered read data and status flags
module param_sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   din,
   input  logic                    wr_en,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   dout,
   output logic                    valid,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  data_count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  rd_acc;
   logic                  wr_acc;

   // A full FIFO still takes a write when a read frees a slot on the same edge.
   assign rd_acc = rd_en && !empty;
   assign wr_acc = wr_en && (!full || rd_acc);

   assign full         = (data_count == DEPTH_C);
   assign empty        = (data_count == '0);
   assign almost_full  = (data_count >= AF_C);
   assign almost_empty = (data_count <= AE_C);

   // Storage is not reset; only the pointers and count define what is held.
   always_ff @(posedge clk) begin
      if (wr_acc && !rst) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         data_count <= '0;
         dout       <= '0;
         valid      <= 1'b0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         valid     <= rd_acc;
         overflow  <= wr_en && full && !rd_acc;
         underflow <= rd_en && empty;
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (wr_acc && !rd_acc) begin
            data_count <= data_count + CW'(1);
         end else if (rd_acc && !wr_acc) begin
            data_count <= data_count - CW'(1);
         end
      end
   end

endmodule
